cv32e40p_tmr_fault_mgr: RTL

CV32E40P_TMR_FAULT_MGR -- requirements
Module: cv32e40p_tmr_fault_mgr

---
 rtl/cv32e40p_tmr_fault_mgr.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cv32e40p_tmr_fault_mgr.sv
// TMR fault manager: classifies voter mismatches as transient or persistent and issues resync pulses.
// Optional feature: define FT_FAULT_LOG_EN to build the per-voter fault log (otherwise fault_log_o is 0).
module cv32e40p_tmr_fault_mgr #(
  parameter int N_VOTERS      = 5,
  parameter int RESYNC_CYCLES = 4,
  parameter int MAX_RETRY     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_VOTERS-1:0] fault_i,
  input  logic                ctrl_idle_i,
  input  logic                clear_i,
  output logic                resync_o,
  output logic                irq_block_o,
  output logic                perm_fault_o,
  output logic [7:0]          fault_cnt_o,
  output logic [N_VOTERS-1:0] fault_log_o,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_RESYNC    = 3'd2,
    S_CHECK     = 3'd3,
    S_PERM      = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cyc;
  logic [2:0] r_retry;
  logic [7:0] r_cnt;
  logic       r_cnt_pend;
  logic       r_resync;
  logic       r_irq_block;
  logic       r_perm;

  logic       w_any;
  logic       w_episode;
  logic       w_retry_hit;
  logic       w_resync_d;
  logic       w_irq_block_d;
  logic       w_perm_d;

  assign w_any       = |fault_i;
  assign w_episode   = (r_state == S_IDLE) && w_any;
  assign w_retry_hit = ((r_retry + 3'd1) == 3'(MAX_RETRY));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!w_any)           w_next = S_IDLE;
        else if (ctrl_idle_i) w_next = S_RESYNC;
      end
      S_RESYNC:    if (r_cyc == 4'd1) w_next = S_CHECK;
      S_CHECK: begin
        if (!w_any)           w_next = S_IDLE;
        else if (w_retry_hit) w_next = S_PERM;
        else                  w_next = S_WAIT_IDLE;
      end
      S_PERM:      if (clear_i) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state exactly
  always_comb begin
    w_resync_d    = (w_next == S_RESYNC);
    w_irq_block_d = (w_next == S_RESYNC) || (w_next == S_CHECK);
    w_perm_d      = (w_next == S_PERM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc       <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_cnt_pend  <= 1'b0;
      r_resync    <= 1'b0;
      r_irq_block <= 1'b0;
      r_perm      <= 1'b0;
    end else begin
      r_resync    <= w_resync_d;
      r_irq_block <= w_irq_block_d;
      r_perm      <= w_perm_d;

      if ((r_state == S_WAIT_IDLE) && (w_next == S_RESYNC)) r_cyc <= 4'(RESYNC_CYCLES);
      else if (r_state == S_RESYNC)                          r_cyc <= r_cyc - 4'd1;

      if (w_episode)                         r_retry <= '0;
      else if ((r_state == S_CHECK) && w_any) r_retry <= r_retry + 3'd1;

      // An episode that collides with a clear is counted a cycle later if it persists
      r_cnt_pend <= w_episode && clear_i;
      if (clear_i)
        r_cnt <= '0;
      else if ((w_episode || (r_cnt_pend && w_any)) && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef FT_FAULT_LOG_EN
  logic [N_VOTERS-1:0] r_log;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_log <= '0;
    else if (clear_i)           r_log <= '0;
    else if (r_state != S_PERM) r_log <= r_log | fault_i;
  end

  assign fault_log_o = r_log;
`else
  assign fault_log_o = '0;
`endif

  assign resync_o     = r_resync;
  assign irq_block_o  = r_irq_block;
  assign perm_fault_o = r_perm;
  assign fault_cnt_o  = r_cnt;
  assign dbg_state_o  = r_state;

endmodule
